// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around mem_port_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Handshake: a requester raises req with stable address/data and holds it
    // until its ready pulses for one cycle; memory answers each mem_en access
    // with a single-cycle mem_ack carrying mem_rdata.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic [1:0]        state_dbg;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_ready, if_rdata, d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, state_dbg
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_ready, if_rdata, d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, state_dbg
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data paths, data first.
// Define ARB_STARVE_GUARD_EN to force a fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          reset,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IF_ACC = 2'd1,
        S_D_ACC  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    state_t            state_q, state_d;
    logic              owner_d_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              starve_trip;
    logic              grant_d, grant_if;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;

    assign starve_trip = (starve_q == 4'(STARVE_MAX)) && bus.if_req;

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else if (grant_if) begin
            starve_q <= 4'd0;
        end else if (grant_d) begin
            starve_q <= bus.if_req ? starve_q + 4'd1 : 4'd0;
        end
    end
`else
    assign starve_trip = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.d_req && !starve_trip) begin
                    state_d = S_D_ACC;
                    grant_d = 1'b1;
                end else if (bus.if_req) begin
                    state_d  = S_IF_ACC;
                    grant_if = 1'b1;
                end
            end
            S_IF_ACC, S_D_ACC: begin
                if (bus.mem_ack) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured at grant so the memory sees a stable access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_d) begin
                owner_d_q <= 1'b1;
                we_q      <= bus.d_we;
                addr_q    <= bus.d_addr;
                wdata_q   <= bus.d_wdata;
            end else if (grant_if) begin
                owner_d_q <= 1'b0;
                we_q      <= 1'b0;
                addr_q    <= bus.if_addr;
            end
            if (bus.mem_ack && state_q == S_IF_ACC) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (bus.mem_ack && state_q == S_D_ACC && !we_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_en    = (state_q == S_IF_ACC) || (state_q == S_D_ACC);
        bus.busy      = (state_q != S_IDLE);
        bus.if_ready  = (state_q == S_DONE) && !owner_d_q;
        bus.d_ready   = (state_q == S_DONE) && owner_d_q;
        bus.state_dbg = state_q;
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
